// File: rtl/io_uart_tx_pkg.sv
// Shared constants and types for the Kabeta IO-bus UART transmitter.
package kabeta_io_pkg;

  localparam int unsigned DIV_W = 16;

  // Register offsets within the 4-word block
  localparam logic [1:0] TXDATA = 2'd0;
  localparam logic [1:0] STATUS = 2'd1;
  localparam logic [1:0] DIV    = 2'd2;
  localparam logic [1:0] CTRL   = 2'd3;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 4;

  // CTRL bit positions
  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/io_uart_tx_if.sv
// Kabeta IO bus: core is master, peripherals are slaves.
interface io_uart_tx_if;
  logic        IO_EnR;
  logic        IO_EnW;
  logic [29:0] IO_Address;
  logic [31:0] IO_DataW;
  logic [31:0] IO_DataR;

  modport master (output IO_EnR, IO_EnW, IO_Address, IO_DataW, input IO_DataR);
  modport slave  (input IO_EnR, IO_EnW, IO_Address, IO_DataW, output IO_DataR);
endinterface

// File: rtl/io_uart_tx_fifo.sv
// Synchronous byte FIFO with first-word fall-through head output.
module io_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 serial transmitter on the Kabeta IO bus.
module io_uart_tx
  import kabeta_io_pkg::*;
#(
  parameter logic [29:0] BASE_ADDR  = 30'h0000_0100,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic         Sys_Clock,
  input  logic         Sys_Reset,
  io_uart_tx_if.slave  io,
  output logic         Dout,
  output logic         Irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic             sel;
  logic [1:0]       offset;
  logic             wr_en;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             ovf_clr;

  logic [DIV_W-1:0] div_q;
  logic             en_q;
  logic             ie_q;
  logic             ovf_q;

  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             dout_d;
  logic             bit_end;
  logic             load;
  logic             busy;

  assign sel     = (io.IO_Address[29:2] == BASE_ADDR[29:2]);
  assign offset  = io.IO_Address[1:0];
  assign wr_en   = io.IO_EnW & sel;
  assign push    = wr_en & (offset == TXDATA);
  assign ovf_set = push & fifo_full;
  assign ovf_clr = wr_en & (offset == STATUS) & io.IO_DataW[STAT_OVF];
  assign busy    = (state_q != ST_IDLE);
  assign bit_end = (baud_q == period_q);

  io_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Sys_Clock),
    .rst_n (Sys_Reset),
    .push  (push),
    .pop   (pop),
    .din   (io.IO_DataW[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Software-visible registers; overflow set beats a same-edge clear
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      div_q <= DIV_RESET;
      en_q  <= 1'b0;
      ie_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en && offset == DIV) div_q <= io.IO_DataW[DIV_W-1:0];
      if (wr_en && offset == CTRL) begin
        en_q <= io.IO_DataW[CTRL_EN];
        ie_q <= io.IO_DataW[CTRL_IE];
      end
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
    end
  end

  // Combinational read mux, zero when not selected
  always_comb begin
    io.IO_DataR = '0;
    if (io.IO_EnR && sel) begin
      case (offset)
        STATUS: begin
          io.IO_DataR[STAT_BUSY]  = busy;
          io.IO_DataR[STAT_FULL]  = fifo_full;
          io.IO_DataR[STAT_EMPTY] = fifo_empty;
          io.IO_DataR[STAT_OVF]   = ovf_q;
          io.IO_DataR[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
        end
        DIV:     io.IO_DataR[DIV_W-1:0] = div_q;
        CTRL: begin
          io.IO_DataR[CTRL_EN] = en_q;
          io.IO_DataR[CTRL_IE] = ie_q;
        end
        default: io.IO_DataR = '0;
      endcase
    end
  end

  // Frame sequencing; Dout is registered from next-state values so the
  // start bit appears on the same edge the FSM enters START
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q && !fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (en_q && !fifo_empty) load = 1'b1;
          else                     state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      state_d  = ST_START;
      pop      = 1'b1;
      shift_d  = fifo_dout;
      period_d = div_q;
      baud_d   = '0;
      bit_d    = '0;
    end
    case (state_d)
      ST_START: dout_d = 1'b0;
      ST_DATA:  dout_d = shift_d[0];
      default:  dout_d = 1'b1;
    endcase
  end

  // FSM, datapath and output registers
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      Dout     <= 1'b1;
      Irq      <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      Dout     <= dout_d;
      Irq      <= ie_q & fifo_empty & ~busy;
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed self-checking bench for io_uart_tx.
module tb_io_uart_tx;

  localparam logic [29:0] BASE   = 30'h0000_0100;
  localparam logic [29:0] A_TX   = BASE;
  localparam logic [29:0] A_ST   = BASE + 30'd1;
  localparam logic [29:0] A_DIV  = BASE + 30'd2;
  localparam logic [29:0] A_CTRL = BASE + 30'd3;

  logic clk;
  logic rst_n;
  logic dout;
  logic irq;
  int   n_checks;
  int   n_errors;

  io_uart_tx_if bus ();

  io_uart_tx #(
    .BASE_ADDR  (30'h0000_0100),
    .FIFO_DEPTH (4),
    .DIV_RESET  (16'd433)
  ) dut (
    .Sys_Clock (clk),
    .Sys_Reset (rst_n),
    .io        (bus),
    .Dout      (dout),
    .Irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [29:0] addr, input logic [31:0] data);
    bus.IO_EnW     = 1'b1;
    bus.IO_Address = addr;
    bus.IO_DataW   = data;
    @(posedge clk);
    #1;
    bus.IO_EnW     = 1'b0;
  endtask

  task automatic rd(input logic [29:0] addr, output logic [31:0] val);
    bus.IO_EnR     = 1'b1;
    bus.IO_Address = addr;
    #1;
    val            = bus.IO_DataR;
    bus.IO_EnR     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level for bit slot idx of a frame: 0 start, 1..8 data LSB first, 9 stop
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  initial begin
    logic [31:0] v;
    logic [7:0]  bytes5 [5];
    bytes5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    n_checks = 0;
    n_errors = 0;
    rst_n          = 1'b0;
    bus.IO_EnR     = 1'b0;
    bus.IO_EnW     = 1'b0;
    bus.IO_Address = '0;
    bus.IO_DataW   = '0;

    // Reset state
    repeat (3) tick();
    check("rst_dout", dout, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_datar", bus.IO_DataR, 32'h0);
    rst_n = 1'b1;
    tick();
    rd(A_ST, v);   check("rst_status", v, 32'h0000_0004);
    rd(A_DIV, v);  check("rst_div", v, 32'd433);
    rd(A_CTRL, v); check("rst_ctrl", v, 32'h0);
    rd(A_TX, v);   check("txdata_read", v, 32'h0);

    // Single frame 0xA5 with DIV=3
    wr(A_DIV, 32'd3);
    wr(A_CTRL, 32'h1);
    wr(A_TX, 32'hA5);
    check("a5_pre", dout, 1'b1);
    for (int j = 0; j < 40; j++) begin
      tick();
      check($sformatf("a5_bit%0d", j), dout, frame_bit(8'hA5, j / 4));
    end
    tick();
    check("a5_idle", dout, 1'b1);
    rd(A_ST, v); check("a5_status", v, 32'h0000_0004);

    // Overflow with EN=0, then drain back-to-back at DIV=0
    wr(A_CTRL, 32'h0);
    wr(A_DIV, 32'd0);
    for (int i = 0; i < 5; i++) wr(A_TX, {24'h0, bytes5[i]});
    rd(A_ST, v); check("ovf_status", v, 32'h0000_004A);
    wr(A_ST, 32'h8);
    rd(A_ST, v); check("ovf_clear", v, 32'h0000_0042);
    wr(A_CTRL, 32'h1);
    for (int j = 0; j < 40; j++) begin
      tick();
      check($sformatf("b2b_bit%0d", j), dout, frame_bit(bytes5[j / 10], j % 10));
    end
    tick();
    check("b2b_idle", dout, 1'b1);
    rd(A_ST, v); check("b2b_status", v, 32'h0000_0004);

    // Interrupt behaviour, DIV=1
    wr(A_DIV, 32'd1);
    wr(A_TX, 32'h3C);
    wr(A_CTRL, 32'h3);
    for (int j = 2; j <= 21; j++) begin
      tick();
      check($sformatf("irq_low%0d", j), irq, 1'b0);
    end
    tick();
    check("irq_rise", irq, 1'b1);
    wr(A_TX, 32'h00);
    check("irq_hold", irq, 1'b1);
    tick();
    check("irq_drop", irq, 1'b0);
    repeat (25) tick();
    check("irq_again", irq, 1'b1);
    wr(A_CTRL, 32'h1);
    tick();
    check("irq_ie_off", irq, 1'b0);

    // DIV change mid-frame, push+pop same edge, reset mid-DATA
    wr(A_TX, 32'h0F);
    wr(A_TX, 32'hF0);
    rd(A_ST, v); check("pushpop_status", v, 32'h0000_0011);
    wr(A_DIV, 32'd7);
    check("div_f1_start", dout, 1'b0);
    for (int j = 3; j <= 20; j++) begin
      tick();
      check($sformatf("div_f1_%0d", j), dout, frame_bit(8'h0F, (j - 1) / 2));
    end
    for (int j = 21; j <= 44; j++) begin
      tick();
      check($sformatf("div_f2_%0d", j), dout, frame_bit(8'hF0, (j - 21) / 8));
    end
    wr(A_TX, 32'h99);
    check("div_f2_45", dout, 1'b0);
    rd(A_ST, v); check("mid_status", v, 32'h0000_0011);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", dout, 1'b1);
    check("midrst_irq", irq, 1'b0);
    rd(A_ST, v); check("midrst_status", v, 32'h0000_0004);
    rst_n = 1'b1;
    tick();
    rd(A_DIV, v); check("midrst_div", v, 32'd433);
    check("midrst_dout2", dout, 1'b1);

    // Accesses outside the block
    wr(BASE + 30'd6, 32'd5);
    wr(BASE + 30'd7, 32'h3);
    wr(BASE + 30'd4, 32'h77);
    rd(BASE + 30'd5, v); check("oob_read", v, 32'h0);
    rd(A_DIV, v);  check("oob_div", v, 32'd433);
    rd(A_CTRL, v); check("oob_ctrl", v, 32'h0);
    rd(A_ST, v);   check("oob_status", v, 32'h0000_0004);
    bus.IO_Address = A_DIV;
    #1;
    check("no_enr_read", bus.IO_DataR, 32'h0);
    repeat (3) tick();
    check("oob_dout", dout, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
